// File: rtl/dac_stream_pkg.sv
// dac_stream_pkg
// Shared definitions for the DAC stream feeder:
//   - feeder_state_e : FSM states IDLE / PRIME / RUN
//   - IDLE_CODE      : per-channel sample value driven while idle (mid-scale in two's complement)
//   - level_width()  : bit width needed to hold a FIFO occupancy of 0..depth
package dac_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } feeder_state_e;

    localparam int IDLE_CODE = 0;

    // Occupancy counts from 0 up to and including depth, hence the extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_frame_fifo.sv
// dac_frame_fifo
// Synchronous single-clock frame FIFO with a synchronous flush.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_flush               : empties the FIFO on the next edge (overrides push/pop)
//   i_push, i_wr_data     : write a frame (ignored when full)
//   i_pop, o_rd_data      : head frame is visible combinationally; i_pop advances it
//   o_full, o_empty       : status derived from the registered level
//   o_level               : frames currently stored
module dac_frame_fifo
    import dac_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 28,
    parameter int DEPTH      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [level_width(DEPTH)-1:0] o_level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = level_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  do_push;
    logic                  do_pop;

    assign o_full    = (level_q == LEVEL_W'(DEPTH));
    assign o_empty   = (level_q == '0);
    assign o_level   = level_q;
    assign o_rd_data = mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) bits, so the increments wrap modulo DEPTH.
    always_comb begin
        do_push  = i_push && !o_full && !i_flush;
        do_pop   = i_pop && !o_empty && !i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only ever read after being written.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

endmodule

// File: rtl/dac_stream_feeder.sv
// dac_stream_feeder
// Buffers multi-channel sample frames from a valid/ready stream and releases one
// frame per programmable sample tick to the Zmod DAC controller data inputs.
// Build option: DAC_UNDERRUN_ZERO_EN - when defined, an underrun tick drives
// o_data to mid-scale (0) with a strobe instead of holding the last sample.
// Ports:
//   i_sys_clock, i_reset          : clock, synchronous active-high reset
//   i_init_done, i_enable         : controller ready / run request; both needed to leave IDLE
//   i_rate_div                    : tick period minus one, in clock cycles
//   i_s_data, i_s_valid, o_s_ready: frame input stream
//   o_data, o_data_strobe         : samples to the controller, pulse on update
//   o_fifo_level                  : frames buffered
//   o_underrun, o_underrun_count  : sticky flag and saturating count, cleared by i_clear_underrun
//   o_running                     : high while in RUN
module dac_stream_feeder
    import dac_stream_pkg::*;
#(
    parameter int ZMOD_DATA_SIZE     = 14,
    parameter int NUM_CHANNELS       = 2,
    parameter int FIFO_DEPTH         = 16,
    parameter int PRIME_LEVEL        = FIFO_DEPTH / 2,
    parameter int RATE_DIV_WIDTH     = 16,
    parameter int UNDERRUN_CNT_WIDTH = 16
) (
    input  logic                                    i_sys_clock,
    input  logic                                    i_reset,
    input  logic                                    i_init_done,
    input  logic                                    i_enable,
    input  logic [RATE_DIV_WIDTH-1:0]               i_rate_div,
    input  logic [NUM_CHANNELS*ZMOD_DATA_SIZE-1:0]  i_s_data,
    input  logic                                    i_s_valid,
    output logic                                    o_s_ready,
    output logic [NUM_CHANNELS*ZMOD_DATA_SIZE-1:0]  o_data,
    output logic                                    o_data_strobe,
    output logic [level_width(FIFO_DEPTH)-1:0]      o_fifo_level,
    output logic                                    o_underrun,
    input  logic                                    i_clear_underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0]           o_underrun_count,
    output logic                                    o_running
);

    localparam int DW      = NUM_CHANNELS * ZMOD_DATA_SIZE;
    localparam int LEVEL_W = level_width(FIFO_DEPTH);
    localparam logic [DW-1:0] IDLE_FRAME = {NUM_CHANNELS{ZMOD_DATA_SIZE'(IDLE_CODE)}};

    feeder_state_e                 state_q, state_d;
    logic [RATE_DIV_WIDTH-1:0]     tick_cnt_q, tick_cnt_d;
    logic [DW-1:0]                 data_q, data_d;
    logic                          strobe_q, strobe_d;
    logic                          underrun_q, underrun_d;
    logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt_q, underrun_cnt_d;

    logic                          go;
    logic                          ready;
    logic                          push;
    logic                          tick;
    logic                          pop;
    logic                          underrun_tick;
    logic                          flush;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [DW-1:0]                 fifo_head;
    logic [LEVEL_W-1:0]            fifo_level;

    dac_frame_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_sys_clock),
        .i_reset    (i_reset),
        .i_flush    (flush),
        .i_push     (push),
        .i_wr_data  (i_s_data),
        .i_pop      (pop),
        .o_rd_data  (fifo_head),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty),
        .o_level    (fifo_level)
    );

    // Control: next state, handshake, tick divider. Losing enable or init-done
    // flushes the FIFO in the same cycle, so a handshake accepted then is dropped.
    always_comb begin
        go            = i_enable && i_init_done;
        ready         = ((state_q == PRIME) || (state_q == RUN)) && !fifo_full;
        push          = i_s_valid && ready;
        flush         = (state_q == IDLE) || !go;
        tick          = (state_q == RUN) && go && (tick_cnt_q == '0);
        pop           = tick && !fifo_empty;
        underrun_tick = tick && fifo_empty;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = PRIME;
            PRIME:   if (!go) state_d = IDLE;
                     else if (fifo_level >= LEVEL_W'(PRIME_LEVEL)) state_d = RUN;
            RUN:     if (!go) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tick_cnt_d = '0;
        if ((state_q == PRIME) && (state_d == RUN)) begin
            tick_cnt_d = i_rate_div;
        end else if ((state_q == RUN) && go) begin
            tick_cnt_d = tick ? i_rate_div : tick_cnt_q - RATE_DIV_WIDTH'(1);
        end
    end

    // Output sample register and underrun statistics. A clear request beats a
    // coincident underrun so software always sees a clean zero afterwards.
    always_comb begin
        data_d   = data_q;
        strobe_d = 1'b0;
        if (flush) begin
            data_d = IDLE_FRAME;
        end else if (pop) begin
            data_d   = fifo_head;
            strobe_d = 1'b1;
        end
`ifdef DAC_UNDERRUN_ZERO_EN
        else if (underrun_tick) begin
            data_d   = IDLE_FRAME;
            strobe_d = 1'b1;
        end
`else
`endif

        underrun_d     = underrun_q;
        underrun_cnt_d = underrun_cnt_q;
        if (i_clear_underrun) begin
            underrun_d     = 1'b0;
            underrun_cnt_d = '0;
        end else if (underrun_tick) begin
            underrun_d = 1'b1;
            if (underrun_cnt_q != '1) begin
                underrun_cnt_d = underrun_cnt_q + UNDERRUN_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_reset) begin
            state_q        <= IDLE;
            tick_cnt_q     <= '0;
            data_q         <= '0;
            strobe_q       <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            data_q         <= data_d;
            strobe_q       <= strobe_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign o_s_ready        = ready;
    assign o_data           = data_q;
    assign o_data_strobe    = strobe_q;
    assign o_fifo_level     = fifo_level;
    assign o_underrun       = underrun_q;
    assign o_underrun_count = underrun_cnt_q;
    assign o_running        = (state_q == RUN);

endmodule

// File: tb/tb_dac_stream_feeder.sv
// tb_dac_stream_feeder
// Directed, self-checking bench for dac_stream_feeder with default parameters.
// Honours DAC_UNDERRUN_ZERO_EN for the expected underrun behaviour.
module tb_dac_stream_feeder;

    localparam int W  = 14;
    localparam int DW = 2 * W;
    localparam int LW = 5;
    localparam int CW = 16;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_done;
    logic          enable;
    logic [RW-1:0] rate_div;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] data;
    logic          data_strobe;
    logic [LW-1:0] fifo_level;
    logic          underrun;
    logic          clear_underrun;
    logic [CW-1:0] underrun_count;
    logic          running;

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        logic [DW-1:0] frame;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    dac_stream_feeder dut (
        .i_sys_clock      (clk),
        .i_reset          (reset),
        .i_init_done      (init_done),
        .i_enable         (enable),
        .i_rate_div       (rate_div),
        .i_s_data         (s_data),
        .i_s_valid        (s_valid),
        .o_s_ready        (s_ready),
        .o_data           (data),
        .o_data_strobe    (data_strobe),
        .o_fifo_level     (fifo_level),
        .o_underrun       (underrun),
        .i_clear_underrun (clear_underrun),
        .o_underrun_count (underrun_count),
        .o_running        (running)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic init, input logic valid,
                                 input logic [DW-1:0] frame);
        enable    = en;
        init_done = init;
        s_valid   = valid;
        s_data    = frame;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] mkFrame(input int s);
        return {W'(s + 100), W'(s)};
    endfunction

    initial begin
        logic [DW-1:0] exp_hold;
        logic [DW-1:0] q [$];
        logic [DW-1:0] exp_front;
        int            exp_strobes;
        int            strobes;
        int            n;
        int            seq;
        int            bp_strobes;
        int            ready_pulses;
        int            ready_at_full;
        int            extra;
        logic          reached_full;
        logic          hs;

        // Frames ch0 = k, ch1 = -k; the expected word spells -k as 2^14 - k.
        for (int k = 1; k <= 8; k++) begin
            vecs[k-1].frame    = {W'(-k), W'(k)};
            vecs[k-1].exp_data = {W'(16384 - k), W'(k)};
        end

        reset          = 1'b1;
        clear_underrun = 1'b0;
        rate_div       = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        checkOutput("rst_ready", 32'(s_ready), 0);
        checkOutput("rst_data", 32'(data), 0);
        checkOutput("rst_strobe", 32'(data_strobe), 0);
        checkOutput("rst_level", 32'(fifo_level), 0);
        checkOutput("rst_underrun", 32'(underrun), 0);
        checkOutput("rst_count", 32'(underrun_count), 0);
        checkOutput("rst_running", 32'(running), 0);
        reset = 1'b0;

        // Init gating: enabled and offering data, but controller not ready.
        applyStimulus(1'b1, 1'b0, 1'b1, vecs[0].frame);
        repeat (3) step();
        checkOutput("gate_ready", 32'(s_ready), 0);
        checkOutput("gate_data", 32'(data), 0);
        checkOutput("gate_level", 32'(fifo_level), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, vecs[0].frame);
        step();
        checkOutput("gate_prime_ready", 32'(s_ready), 1);
        checkOutput("gate_prime_running", 32'(running), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);

        // Prime with 8 frames, then drain at one tick every 4 cycles.
        rate_div = RW'(3);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, vecs[i].frame);
            step();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("prime_level", 32'(fifo_level), 8);
        checkOutput("prime_not_running", 32'(running), 0);
        step();
        checkOutput("run_entered", 32'(running), 1);

        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!data_strobe && n < 20);
            checkOutput($sformatf("drain_strobe%0d", i), 32'(data_strobe), 1);
            checkOutput($sformatf("drain_gap%0d", i), 32'(n), 4);
            checkOutput($sformatf("drain_data%0d", i), 32'(data), 32'(vecs[i].exp_data));
        end
        checkOutput("drain_level", 32'(fifo_level), 0);

        // Five underrun ticks with nothing queued.
`ifdef DAC_UNDERRUN_ZERO_EN
        exp_hold    = '0;
        exp_strobes = 5;
`else
        exp_hold    = vecs[7].exp_data;
        exp_strobes = 0;
`endif
        strobes = 0;
        repeat (20) begin
            step();
            if (data_strobe) strobes++;
        end
        checkOutput("ur_flag", 32'(underrun), 1);
        checkOutput("ur_count", 32'(underrun_count), 5);
        checkOutput("ur_data", 32'(data), 32'(exp_hold));
        checkOutput("ur_strobes", 32'(strobes), 32'(exp_strobes));
        checkOutput("ur_running", 32'(running), 1);

        // Clear coincides with the sixth underrun tick.
        repeat (3) step();
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        checkOutput("clr_flag", 32'(underrun), 0);
        checkOutput("clr_count", 32'(underrun_count), 0);
        rate_div = RW'(1000);
        repeat (4) step();
        checkOutput("clr_recount", 32'(underrun_count), 1);
        checkOutput("clr_reflag", 32'(underrun), 1);

        // Abort with 5 frames queued.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, vecs[i].frame);
            step();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("abort_queued", 32'(fifo_level), 5);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        step();
        checkOutput("abort_level", 32'(fifo_level), 0);
        checkOutput("abort_data", 32'(data), 0);
        checkOutput("abort_running", 32'(running), 0);
        checkOutput("abort_count", 32'(underrun_count), 1);
        checkOutput("abort_ready", 32'(s_ready), 0);

        // Full backpressure with a slow tick and continuous pushes.
        seq           = 0;
        bp_strobes    = 0;
        ready_pulses  = 0;
        ready_at_full = 0;
        extra         = 0;
        reached_full  = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, mkFrame(seq));
        for (int c = 0; c < 3000 && extra < 3; c++) begin
            hs = s_ready && s_valid;
            step();
            if (hs) begin
                q.push_back(s_data);
                seq++;
                s_data = mkFrame(seq);
            end
            if (data_strobe) begin
                exp_front = (q.size() > 0) ? q.pop_front() : '0;
                checkOutput($sformatf("bp_data%0d", bp_strobes), 32'(data), 32'(exp_front));
                bp_strobes++;
            end
            if (fifo_level == LW'(16) && s_ready) ready_at_full++;
            if (reached_full && s_ready) ready_pulses++;
            if (fifo_level == LW'(16)) reached_full = 1'b1;
            if (bp_strobes >= 2) extra++;
        end
        s_valid = 1'b0;
        checkOutput("bp_strobes", 32'(bp_strobes), 2);
        checkOutput("bp_ready_at_full", 32'(ready_at_full), 0);
        checkOutput("bp_ready_pulses", 32'(ready_pulses), 2);
        checkOutput("bp_level", 32'(fifo_level), 16);
        checkOutput("bp_queue", 32'(q.size()), 16);

        // Reset mid-operation wipes statistics too.
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("mid_rst_level", 32'(fifo_level), 0);
        checkOutput("mid_rst_running", 32'(running), 0);
        checkOutput("mid_rst_count", 32'(underrun_count), 0);
        checkOutput("mid_rst_flag", 32'(underrun), 0);
        checkOutput("mid_rst_data", 32'(data), 0);
        checkOutput("mid_rst_ready", 32'(s_ready), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/dac_stream_feeder.md
Name: dac_stream_feeder

Overview:
- Parametrised N-channel sample feeder that sits in front of the Zmod DAC controller in the system clock domain.
- Accepts multi-channel sample frames over a valid/ready stream and buffers them in a frame FIFO.
- Releases one frame per programmable sample tick to the controller's per-channel data inputs.
- Primes before starting, detects and counts underruns, and gates everything on the controller's init-done status.

Parameters:
- ZMOD_DATA_SIZE, 14, bits per channel sample (two's complement, as the controller expects).
- NUM_CHANNELS, 2, channels per frame (1..8).
- FIFO_DEPTH, 16, frames buffered; power of two, >= 4.
- PRIME_LEVEL, FIFO_DEPTH/2, frames required before the first tick in RUN; 1..FIFO_DEPTH.
- RATE_DIV_WIDTH, 16, width of the sample-rate divider.
- UNDERRUN_CNT_WIDTH, 16, width of the saturating underrun counter.

Ports:
- i_sys_clock  in  1  single clock for the entire block.
- i_reset  in  1  synchronous, active-high reset.
- i_init_done  in  1  high once the DAC controller has finished initialisation.
- i_enable  in  1  run request.
- i_rate_div  in  RATE_DIV_WIDTH  tick period minus 1, in i_sys_clock cycles.
- i_s_data  in  NUM_CHANNELS*ZMOD_DATA_SIZE  frame; channel k occupies bits [k*W +: W].
- i_s_valid  in  1  frame valid.
- o_s_ready  out  1  frame accepted when i_s_valid && o_s_ready.
- o_data  out  NUM_CHANNELS*ZMOD_DATA_SIZE  per-channel samples to the controller.
- o_data_strobe  out  1  one-cycle pulse when o_data updates from the FIFO.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- o_underrun  out  1  sticky underrun flag.
- i_clear_underrun  in  1  clears o_underrun and o_underrun_count.
- o_underrun_count  out  UNDERRUN_CNT_WIDTH  saturating underrun count.
- o_running  out  1  high while in RUN.

Behaviour:
- Reset values: o_s_ready=0, o_data=0, o_data_strobe=0, o_fifo_level=0, o_underrun=0, o_underrun_count=0, o_running=0. FSM enters IDLE; FIFO empty; tick counter 0.
- State IDLE:
  - o_s_ready=0, FIFO held flushed, o_data=0.
  - Moves to PRIME when i_enable && i_init_done.
- State PRIME:
  - o_s_ready = !full.
  - Moves to RUN in the cycle after level >= PRIME_LEVEL.
  - Tick counter loads i_rate_div on entry to RUN.
- State RUN:
  - o_running=1, o_s_ready = !full.
  - Counter decrements each cycle. At 0 a tick fires and the counter reloads i_rate_div, sampled at reload, so the tick period is i_rate_div+1 cycles. i_rate_div=0 gives a tick every cycle.
- Tick with FIFO non-empty:
  - Pop the head frame in the tick cycle.
  - o_data and o_data_strobe update on the next clock edge (latency 1 from tick).
- Tick with FIFO empty (underrun):
  - No strobe; o_data holds its last value.
  - o_underrun set; o_underrun_count increments, saturating at all-ones.
  - Remain in RUN; no re-prime.
- Leaving RUN/PRIME:
  - i_enable=0 or i_init_done=0 in any non-IDLE state moves the FSM to IDLE next cycle.
  - The FIFO is flushed and o_data clears to 0 on the same edge.
  - Any in-flight handshake in that cycle is dropped.
  - Underrun statistics are preserved.
- FIFO accounting:
  - Push and pop in the same cycle: level unchanged. A push is allowed only when not full, since ready is computed from the registered full flag.
  - Write at full is impossible (ready=0). Read at empty is never issued.
  - Pointers wrap modulo FIFO_DEPTH.
- i_clear_underrun coincident with an underrun tick: clear wins; flag and count both read 0 afterwards.
- Reset asserted mid-operation: everything returns to reset values on that edge, including the statistics.

Optional Feature:
- Macro: DAC_UNDERRUN_ZERO_EN.
- Defined: on an underrun tick, o_data is driven to 0 (mid-scale) on the next edge and o_data_strobe pulses, so the DAC output parks at mid-scale instead of holding.
- Undefined: o_data holds its last value and no strobe is issued, as described above.

Decomposition:
- Package dac_stream_pkg holds:
  - the FSM state enum {IDLE, PRIME, RUN};
  - the IDLE_CODE constant (0);
  - a helper function for the level width, $clog2(FIFO_DEPTH)+1.
- One sub-module, dac_frame_fifo:
  - synchronous FIFO of width NUM_CHANNELS*ZMOD_DATA_SIZE and depth FIFO_DEPTH;
  - provides full, empty, level and a synchronous flush input.
- The top level holds the FSM, the tick divider and the underrun logic.

Test Plan:
- Prime and drain: defaults, i_rate_div=3. Push 8 frames with ch0=k, ch1=-k (k=1..8).
  - RUN entered after the 8th push.
  - Strobes arrive exactly 4 cycles apart; o_data sequence matches the pushed frames.
- Underrun: after the above drain, with no further pushes, run 5 more ticks.
  - o_underrun=1, o_underrun_count=5.
  - o_data holds {ch0=8, ch1=-8}, or reads 0 with strobes when DAC_UNDERRUN_ZERO_EN is defined.
- Full backpressure: i_rate_div=1000, push continuously.
  - o_s_ready drops when o_fifo_level=16.
  - It rises for one cycle after each tick pop.
  - No frame is lost or duplicated.
- Init gating: i_init_done=0 with i_enable=1 and i_s_valid=1.
  - o_s_ready stays 0 and o_data stays 0.
  - Raising i_init_done moves the FSM to PRIME on the next edge.
- Abort mid-run: deassert i_enable with 5 frames queued.
  - Next cycle: o_fifo_level=0, o_data=0, o_running=0.
  - o_underrun_count is unchanged.
- Clear collision: assert i_clear_underrun in the same cycle as an underrun tick; flag and count both read 0 the next cycle.
